// File: rtl/prgrm_cnt_stk.sv
// -----------------------------------------------------------------------------
// prgrm_cnt_stk
//   Program counter with a LIFO return-address stack. During the WRITEBACK
//   cycle one of three strobes updates the PC. A return pops the PC from the
//   stack. A branch loads the PC from the instruction, and a branch that is a
//   call also pushes PC+1. An increment advances the PC by one. All updates
//   become visible one clock after the strobe is sampled.
//
// Ports
//   clk            : single clock, rising-edge active
//   Reset          : synchronous active-high reset, overrides every strobe
//   Incrmnt_PC     : advance PC by one (lowest priority)
//   Ld_Brnch_Addr  : load PC from Crnt_Instrn[PC_WIDTH-1:0]; push if bit 28 set
//   Ld_Rtn_Addr    : pop return address into PC (highest priority)
//   Crnt_Instrn    : current instruction word (target in low bits, bit 28 = call)
//   PC             : registered program counter
//   Stk_Cnt        : number of occupied stack entries (0..STK_DEPTH)
//   Stk_Full       : Stk_Cnt == STK_DEPTH
//   Stk_Empty      : Stk_Cnt == 0
//   Stk_Err        : sticky overflow/underflow flag, cleared only by Reset
// -----------------------------------------------------------------------------
module prgrm_cnt_stk #(
  parameter int PC_WIDTH  = 8,
  parameter int STK_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         Incrmnt_PC,
  input  logic                         Ld_Brnch_Addr,
  input  logic                         Ld_Rtn_Addr,
  input  logic [31:0]                  Crnt_Instrn,
  output logic [PC_WIDTH-1:0]          PC,
  output logic [$clog2(STK_DEPTH):0]   Stk_Cnt,
  output logic                         Stk_Full,
  output logic                         Stk_Empty,
  output logic                         Stk_Err
);

  localparam int PTR_W = $clog2(STK_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CALL_BIT = 28;

  logic [PC_WIDTH-1:0] stk_mem [STK_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                err_nxt;
  logic                push;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  // Stk_Cnt doubles as the write pointer; the top of stack sits one below it.
  assign wr_ptr = Stk_Cnt[PTR_W-1:0];
  assign rd_ptr = wr_ptr - PTR_W'(1);

  // Natural width wrap gives the required modulo-2^PC_WIDTH increment.
  assign pc_inc = PC + PC_WIDTH'(1);

  assign Stk_Full  = (Stk_Cnt == CNT_W'(STK_DEPTH));
  assign Stk_Empty = (Stk_Cnt == '0);

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_nxt  = PC;
    cnt_nxt = Stk_Cnt;
    err_nxt = Stk_Err;
    push    = 1'b0;

    if (Ld_Rtn_Addr) begin
      if (!Stk_Empty) begin
        pc_nxt  = stk_mem[rd_ptr];
        cnt_nxt = Stk_Cnt - CNT_W'(1);
      end else begin
        // Underflow: step past the bad return and flag it.
        pc_nxt  = pc_inc;
        err_nxt = 1'b1;
      end
    end else if (Ld_Brnch_Addr) begin
      pc_nxt = Crnt_Instrn[PC_WIDTH-1:0];
      if (Crnt_Instrn[CALL_BIT]) begin
        if (!Stk_Full) begin
          push    = 1'b1;
          cnt_nxt = Stk_Cnt + CNT_W'(1);
        end else begin
          // Overflow: the branch still happens, the return address is lost.
          err_nxt = 1'b1;
        end
      end
    end else if (Incrmnt_PC) begin
      pc_nxt = pc_inc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same clock edge.
  always_ff @(posedge clk) begin
    if (Reset) begin
      PC      <= '0;
      Stk_Cnt <= '0;
      Stk_Err <= 1'b0;
    end else begin
      PC      <= pc_nxt;
      Stk_Cnt <= cnt_nxt;
      Stk_Err <= err_nxt;
    end
  end

  // NOTE: the stack storage has no reset. Entries at or above Stk_Cnt are
  // never read, so clearing Stk_Cnt alone discards the stack contents.
  always_ff @(posedge clk) begin
    if (push && !Reset) begin
      stk_mem[wr_ptr] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_prgrm_cnt_stk.sv
// -----------------------------------------------------------------------------
// tb_prgrm_cnt_stk
//   Directed testbench for prgrm_cnt_stk (PC_WIDTH=8, STK_DEPTH=8). Inputs are
//   driven just after a rising edge and outputs are sampled 1 ns after the
//   following edge.
// -----------------------------------------------------------------------------
module tb_prgrm_cnt_stk;

  localparam int PC_WIDTH  = 8;
  localparam int STK_DEPTH = 8;
  localparam logic [31:0] CALL = 32'h1000_0000;

  logic        clk;
  logic        Reset;
  logic        Incrmnt_PC;
  logic        Ld_Brnch_Addr;
  logic        Ld_Rtn_Addr;
  logic [31:0] Crnt_Instrn;
  logic [7:0]  PC;
  logic [3:0]  Stk_Cnt;
  logic        Stk_Full;
  logic        Stk_Empty;
  logic        Stk_Err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_pc;
  logic [7:0] exp_stk [STK_DEPTH];

  prgrm_cnt_stk #(
    .PC_WIDTH  (PC_WIDTH),
    .STK_DEPTH (STK_DEPTH)
  ) dut (
    .clk           (clk),
    .Reset         (Reset),
    .Incrmnt_PC    (Incrmnt_PC),
    .Ld_Brnch_Addr (Ld_Brnch_Addr),
    .Ld_Rtn_Addr   (Ld_Rtn_Addr),
    .Crnt_Instrn   (Crnt_Instrn),
    .PC            (PC),
    .Stk_Cnt       (Stk_Cnt),
    .Stk_Full      (Stk_Full),
    .Stk_Empty     (Stk_Empty),
    .Stk_Err       (Stk_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Apply one set of strobes for a single clock, then sample after the edge.
  task automatic cycle(input logic rst, input logic inc, input logic br,
                       input logic rt, input logic [31:0] instr);
    Reset         = rst;
    Incrmnt_PC    = inc;
    Ld_Brnch_Addr = br;
    Ld_Rtn_Addr   = rt;
    Crnt_Instrn   = instr;
    @(posedge clk);
    #1;
    Reset         = 1'b0;
    Incrmnt_PC    = 1'b0;
    Ld_Brnch_Addr = 1'b0;
    Ld_Rtn_Addr   = 1'b0;
    Crnt_Instrn   = '0;
  endtask

  initial begin
    Reset = 1'b0; Incrmnt_PC = 1'b0; Ld_Brnch_Addr = 1'b0;
    Ld_Rtn_Addr = 1'b0; Crnt_Instrn = '0;

    // Reset state
    cycle(1, 0, 0, 0, 0);
    check("rst_pc",    PC,        0);
    check("rst_cnt",   Stk_Cnt,   0);
    check("rst_empty", Stk_Empty, 1);
    check("rst_full",  Stk_Full,  0);
    check("rst_err",   Stk_Err,   0);

    // Increment three times
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 1, 0, 0, 0);
      check($sformatf("inc_pc%0d", i), PC, i);
    end
    check("inc_empty", Stk_Empty, 1);
    check("inc_err",   Stk_Err,   0);

    // Branch beats increment; a jump leaves the stack alone
    cycle(0, 1, 1, 0, 32'h0000_0044);
    check("br_over_inc_pc", PC, 8'h44);
    cycle(0, 0, 1, 0, 32'h0000_0010);
    check("jump_pc",  PC,      8'h10);
    check("jump_cnt", Stk_Cnt, 0);

    // Call and return
    cycle(0, 0, 1, 0, CALL | 32'h40);
    check("call_pc",    PC,        8'h40);
    check("call_cnt",   Stk_Cnt,   1);
    check("call_empty", Stk_Empty, 0);
    cycle(0, 0, 0, 0, 0);
    check("hold_pc",  PC,      8'h40);
    check("hold_cnt", Stk_Cnt, 1);
    cycle(0, 0, 0, 1, 0);
    check("ret_pc",  PC,      8'h11);
    check("ret_cnt", Stk_Cnt, 0);

    // Eight nested calls fill the stack
    exp_pc = 8'h11;
    for (int k = 0; k < STK_DEPTH; k++) begin
      logic [7:0] tgt;
      tgt = 8'h30 + 8'(k * 4);
      exp_stk[k] = exp_pc + 8'd1;
      cycle(0, 0, 1, 0, CALL | 32'(tgt));
      exp_pc = tgt;
      check($sformatf("nest_pc%0d", k),  PC,      exp_pc);
      check($sformatf("nest_cnt%0d", k), Stk_Cnt, k + 1);
    end
    check("nest_full", Stk_Full, 1);
    check("nest_err",  Stk_Err,  0);

    // Ninth call overflows: branch taken, push dropped, error flagged
    cycle(0, 0, 1, 0, CALL | 32'h80);
    check("ovf_pc",   PC,       8'h80);
    check("ovf_cnt",  Stk_Cnt,  8);
    check("ovf_err",  Stk_Err,  1);
    check("ovf_full", Stk_Full, 1);

    // Returns unwind in reverse push order
    for (int k = STK_DEPTH - 1; k >= 0; k--) begin
      cycle(0, 0, 0, 1, 0);
      check($sformatf("pop_pc%0d", k),  PC,      exp_stk[k]);
      check($sformatf("pop_cnt%0d", k), Stk_Cnt, k);
    end
    check("pop_empty",    Stk_Empty, 1);
    check("pop_err_held", Stk_Err,   1);

    // Underflow
    cycle(1, 0, 0, 0, 0);
    check("rst2_err", Stk_Err, 0);
    cycle(0, 0, 1, 0, 32'h0000_0022);
    cycle(0, 0, 0, 1, 0);
    check("unf_pc",  PC,      8'h23);
    check("unf_err", Stk_Err, 1);
    check("unf_cnt", Stk_Cnt, 0);
    cycle(0, 1, 0, 0, 0);
    check("unf_inc_pc", PC,      8'h24);
    check("err_sticky", Stk_Err, 1);

    // Wrap from 0xFF to 0x00 without error
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 32'h0000_00FF);
    cycle(0, 1, 0, 0, 0);
    check("wrap_pc",  PC,      8'h00);
    check("wrap_err", Stk_Err, 0);

    // Priority: return beats branch and increment
    cycle(0, 0, 1, 0, 32'h0000_0054);
    cycle(0, 0, 1, 0, CALL | 32'h90);
    check("pri_setup_cnt", Stk_Cnt, 1);
    cycle(0, 1, 1, 1, CALL | 32'hA0);
    check("pri_pc",  PC,      8'h55);
    check("pri_cnt", Stk_Cnt, 0);
    check("pri_err", Stk_Err, 0);

    // Reset coinciding with a call
    cycle(0, 0, 1, 0, CALL | 32'h60);
    check("rc_setup_cnt", Stk_Cnt, 1);
    cycle(1, 0, 1, 0, CALL | 32'h70);
    check("rst_call_pc",    PC,        0);
    check("rst_call_cnt",   Stk_Cnt,   0);
    check("rst_call_err",   Stk_Err,   0);
    check("rst_call_empty", Stk_Empty, 1);
    cycle(0, 0, 0, 1, 0);
    check("rst_call_unf_pc",  PC,      8'h01);
    check("rst_call_unf_err", Stk_Err, 1);

    // Reset coinciding with a return
    cycle(0, 0, 1, 0, CALL | 32'h33);
    check("rr_setup_cnt", Stk_Cnt, 1);
    cycle(1, 0, 0, 1, 0);
    check("rst_ret_pc",  PC,      0);
    check("rst_ret_cnt", Stk_Cnt, 0);
    check("rst_ret_err", Stk_Err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
